// File: rtl/tx_frame_builder.sv
// tx_frame_builder: assembles a 54-byte Ethernet/IPv4/TCP header from
// start-time fields, then streams the payload realigned by six byte lanes.
module tx_frame_builder (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    input  logic [47:0] dst_mac,
    input  logic [47:0] src_mac,
    input  logic [31:0] src_ip,
    input  logic [31:0] dst_ip,
    input  logic [15:0] ip_id,
    input  logic [15:0] src_port,
    input  logic [15:0] dst_port,
    input  logic [31:0] tcp_seq,
    input  logic [31:0] tcp_ack,
    input  logic [7:0]  tcp_flags,
    input  logic [15:0] tcp_window,
    input  logic [15:0] payload_len,
    input  logic [63:0] s_tdata,
    input  logic [7:0]  s_tkeep,
    input  logic        s_tvalid,
    input  logic        s_tlast,
    output logic        s_tready,
    output logic [63:0] m_tdata,
    output logic [7:0]  m_tkeep,
    output logic        m_tvalid,
    output logic        m_tlast,
    input  logic        m_tready
);

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_HDR, S_W6, S_PAY, S_FLUSH
    } state_t;

    state_t      state, state_nxt;

    logic [47:0] dst_mac_q, src_mac_q;
    logic [31:0] src_ip_q, dst_ip_q, tcp_seq_q, tcp_ack_q;
    logic [15:0] ip_id_q, src_port_q, dst_port_q, tcp_window_q, pay_len_q;
    logic [7:0]  tcp_flags_q;
    logic [15:0] csum_q;
    logic [2:0]  beat_q;
    logic [47:0] resid_q;
    logic [3:0]  resid_n_q;

    logic        accept, can_load, pay_take, in_close, load;
    logic [3:0]  in_cnt;
    logic [15:0] tot_len;
    logic [19:0] csum_sum;
    logic [431:0] hdr_wire, hdr_lane;
    logic [63:0] out_data_nxt;
    logic [7:0]  out_keep_nxt;
    logic        out_last_nxt;

    // Fold end-around carries of a one's-complement sum into 16 bits.
    function automatic logic [15:0] ones_fold(input logic [19:0] s);
        logic [16:0] t;
        t = {1'b0, s[15:0]} + {13'd0, s[19:16]};
        return t[15:0] + {15'd0, t[16]};
    endfunction

    // Number of valid bytes in a lane-0-contiguous keep mask.
    function automatic logic [3:0] keep_count(input logic [7:0] k);
        logic [3:0] c;
        c = 4'd0;
        for (int i = 0; i < 8; i++) c = c + {3'd0, k[i]};
        return c;
    endfunction

    // Zero the byte lanes that keep marks as invalid.
    function automatic logic [63:0] mask_data(input logic [63:0] d, input logic [7:0] k);
        logic [63:0] r;
        for (int i = 0; i < 8; i++) r[8*i +: 8] = k[i] ? d[8*i +: 8] : 8'h00;
        return r;
    endfunction

    assign accept   = start && (state == S_IDLE) && !busy;
    assign can_load = !m_tvalid || m_tready;
    assign in_cnt   = keep_count(s_tkeep);
    assign in_close = s_tlast && (in_cnt <= 4'd2);
    assign pay_take = s_tready && s_tvalid;
    assign tot_len  = pay_len_q + 16'd40;

    // IPv4 header checksum over the ten header words, checksum word as zero.
    always_comb begin
        csum_sum = 20'h04500 + {4'd0, tot_len} + {4'd0, ip_id_q} + 20'h04000 + 20'h04006
                 + {4'd0, src_ip_q[31:16]} + {4'd0, src_ip_q[15:0]}
                 + {4'd0, dst_ip_q[31:16]} + {4'd0, dst_ip_q[15:0]};
    end

    // Header in wire order (byte 0 at the MSB), then byte-swapped so byte n sits in lane bits [8n+7:8n].
    always_comb begin
        hdr_wire = {dst_mac_q, src_mac_q, 16'h0800,
                    8'h45, 8'h00, tot_len, ip_id_q, 16'h4000, 8'h40, 8'h06, csum_q,
                    src_ip_q, dst_ip_q,
                    src_port_q, dst_port_q, tcp_seq_q, tcp_ack_q,
                    8'h50, tcp_flags_q, tcp_window_q, 16'h0000, 16'h0000};
        hdr_lane = '0;
        for (int n = 0; n < 54; n++) hdr_lane[8*n +: 8] = hdr_wire[431 - 8*n -: 8];
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:  if (accept) state_nxt = S_CALC;
            S_CALC:  state_nxt = S_HDR;
            S_HDR:   if (can_load && beat_q == 3'd5) state_nxt = S_W6;
            S_W6: begin
                if (pay_len_q == 16'd0) begin
                    if (can_load) state_nxt = S_IDLE;
                end else if (pay_take) begin
                    if (!s_tlast)     state_nxt = S_PAY;
                    else if (in_close) state_nxt = S_IDLE;
                    else              state_nxt = S_FLUSH;
                end
            end
            S_PAY: begin
                if (pay_take && s_tlast) state_nxt = in_close ? S_IDLE : S_FLUSH;
            end
            S_FLUSH: if (can_load) state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Output decode: payload ready and the beat to load into the output register.
    always_comb begin
        s_tready     = 1'b0;
        load         = 1'b0;
        out_data_nxt = 64'd0;
        out_keep_nxt = 8'd0;
        out_last_nxt = 1'b0;
        case (state)
            S_HDR: begin
                load         = can_load;
                out_data_nxt = hdr_lane[{beat_q, 6'd0} +: 64];
                out_keep_nxt = 8'hFF;
            end
            S_W6: begin
                if (pay_len_q == 16'd0) begin
                    load         = can_load;
                    out_data_nxt = {16'h0000, hdr_lane[431:384]};
                    out_keep_nxt = 8'h3F;
                    out_last_nxt = 1'b1;
                end else begin
                    s_tready     = can_load;
                    load         = can_load && s_tvalid;
                    out_keep_nxt = {s_tkeep[1:0], 6'h3F};
                    out_data_nxt = mask_data({s_tdata[15:0], hdr_lane[431:384]}, out_keep_nxt);
                    out_last_nxt = in_close;
                end
            end
            S_PAY: begin
                s_tready     = can_load;
                load         = can_load && s_tvalid;
                out_keep_nxt = {s_tkeep[1:0], 6'h3F};
                out_data_nxt = mask_data({s_tdata[15:0], resid_q}, out_keep_nxt);
                out_last_nxt = in_close;
            end
            S_FLUSH: begin
                load         = can_load;
                out_keep_nxt = (8'd1 << resid_n_q) - 8'd1;
                out_data_nxt = mask_data({16'h0000, resid_q}, out_keep_nxt);
                out_last_nxt = 1'b1;
            end
            default: ;
        endcase
    end

    // Control: busy flag and header beat counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= 1'b0;
            beat_q <= 3'd0;
        end else begin
            if (accept)                           busy <= 1'b1;
            else if (m_tvalid && m_tready && m_tlast) busy <= 1'b0;
            if (state == S_CALC)                  beat_q <= 3'd0;
            else if (state == S_HDR && can_load)  beat_q <= beat_q + 3'd1;
        end
    end

    // Output register: loads a new beat or empties on handshake, holds while stalled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
            m_tkeep  <= 8'd0;
            m_tdata  <= 64'd0;
        end else if (load) begin
            m_tvalid <= 1'b1;
            m_tlast  <= out_last_nxt;
            m_tkeep  <= out_keep_nxt;
            m_tdata  <= out_data_nxt;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
            m_tlast  <= 1'b0;
        end
    end

    // Datapath: header fields on start, checksum in CALC, payload residual on each input beat.
    always_ff @(posedge clk) begin
        if (accept) begin
            dst_mac_q    <= dst_mac;
            src_mac_q    <= src_mac;
            src_ip_q     <= src_ip;
            dst_ip_q     <= dst_ip;
            ip_id_q      <= ip_id;
            src_port_q   <= src_port;
            dst_port_q   <= dst_port;
            tcp_seq_q    <= tcp_seq;
            tcp_ack_q    <= tcp_ack;
            tcp_flags_q  <= tcp_flags;
            tcp_window_q <= tcp_window;
            pay_len_q    <= payload_len;
        end
        if (state == S_CALC) csum_q <= ~ones_fold(csum_sum);
        if (pay_take) begin
            resid_q   <= s_tdata[63:16];
            resid_n_q <= in_cnt - 4'd2;
        end
    end

endmodule

// File: tb/tb_tx_frame_builder.sv
// Bench for tx_frame_builder: byte-stream reference model plus literal frame checks.
module tb_tx_frame_builder;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic [47:0] dst_mac, src_mac;
    logic [31:0] src_ip, dst_ip, tcp_seq, tcp_ack;
    logic [15:0] ip_id, src_port, dst_port, tcp_window, payload_len;
    logic [7:0]  tcp_flags;
    logic [63:0] s_tdata;
    logic [7:0]  s_tkeep;
    logic        s_tvalid, s_tlast, s_tready;
    logic [63:0] m_tdata;
    logic [7:0]  m_tkeep;
    logic        m_tvalid, m_tlast, m_tready;

    int checks = 0;
    int errors = 0;
    bit thr_en = 1'b0;

    logic [63:0] exp_d[$];
    logic [7:0]  exp_k[$];
    logic        exp_l[$];
    logic [63:0] cap_d[$];
    logic [7:0]  cap_k[$];
    logic        cap_l[$];

    logic [7:0]  frame_b [0:1599];
    logic [7:0]  pay_b   [0:1499];
    logic [15:0] model_csum;

    tx_frame_builder dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy),
        .dst_mac(dst_mac), .src_mac(src_mac), .src_ip(src_ip), .dst_ip(dst_ip),
        .ip_id(ip_id), .src_port(src_port), .dst_port(dst_port),
        .tcp_seq(tcp_seq), .tcp_ack(tcp_ack), .tcp_flags(tcp_flags),
        .tcp_window(tcp_window), .payload_len(payload_len),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tvalid(s_tvalid), .s_tlast(s_tlast),
        .s_tready(s_tready),
        .m_tdata(m_tdata), .m_tkeep(m_tkeep), .m_tvalid(m_tvalid), .m_tlast(m_tlast),
        .m_tready(m_tready)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", nm, act, req);
        end
    endtask

    task automatic randomize_fields();
        dst_mac    = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        src_mac    = {$urandom, $urandom} & 48'hFFFF_FFFF_FFFF;
        src_ip     = $urandom;
        dst_ip     = $urandom;
        ip_id      = 16'($urandom);
        src_port   = 16'($urandom);
        dst_port   = 16'($urandom);
        tcp_seq    = $urandom;
        tcp_ack    = $urandom;
        tcp_flags  = 8'($urandom);
        tcp_window = 16'($urandom);
    endtask

    // Reference: whole frame as a byte array, chunked into 8-byte beats.
    task automatic build_expected(input int plen);
        logic [431:0] w;
        int sum, total, nb;
        logic [63:0] d;
        logic [7:0]  k;
        w = {dst_mac, src_mac, 16'h0800, 8'h45, 8'h00, 16'(plen + 40), ip_id, 16'h4000,
             8'h40, 8'h06, 16'h0000, src_ip, dst_ip, src_port, dst_port, tcp_seq, tcp_ack,
             8'h50, tcp_flags, tcp_window, 32'h0};
        for (int i = 0; i < 54; i++) frame_b[i] = w[431 - 8*i -: 8];
        sum = 0;
        for (int i = 0; i < 10; i++) sum += {frame_b[14 + 2*i], frame_b[15 + 2*i]};
        while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
        model_csum = ~sum[15:0];
        frame_b[24] = model_csum[15:8];
        frame_b[25] = model_csum[7:0];
        for (int i = 0; i < plen; i++) frame_b[54 + i] = pay_b[i];
        total = 54 + plen;
        nb = (total + 7) / 8;
        for (int b = 0; b < nb; b++) begin
            d = 64'd0;
            k = 8'd0;
            for (int j = 0; j < 8; j++) begin
                if (b*8 + j < total) begin
                    d[8*j +: 8] = frame_b[b*8 + j];
                    k[j] = 1'b1;
                end
            end
            exp_d.push_back(d);
            exp_k.push_back(k);
            exp_l.push_back(b == nb - 1);
        end
    endtask

    task automatic run_frame(input int plen, input bit fixed, input bit check_lat,
                             input bit start_busy, input int abort_at);
        int nin, idx, cyc, rem;
        bit hs, done;
        if (fixed) begin
            dst_mac = 48'hDA0203040506; src_mac = 48'h5A0203040506;
            src_ip = 32'hC0A80101; dst_ip = 32'hC0A80102; ip_id = 16'h1234;
            src_port = 16'h04D2; dst_port = 16'h0050; tcp_seq = 32'd1; tcp_ack = 32'd0;
            tcp_flags = 8'h02; tcp_window = 16'h7210;
        end else begin
            randomize_fields();
        end
        payload_len = 16'(plen);
        for (int i = 0; i < plen; i++) pay_b[i] = fixed ? 8'(i + 1) : 8'($urandom);
        build_expected(plen);
        cap_d.delete(); cap_k.delete(); cap_l.delete();
        nin = (plen + 7) / 8;
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        if (check_lat) begin
            chk("busy_after_start", busy, 1'b1);
            chk("no_valid_at_n", m_tvalid, 1'b0);
        end
        randomize_fields();
        payload_len = 16'($urandom_range(0, 1446));
        idx = 0; cyc = 0; done = 1'b0;
        while (!done && cyc < 4000) begin
            if (idx < nin) begin
                if (!s_tvalid) s_tvalid = thr_en ? ($urandom_range(0, 3) != 0) : 1'b1;
                rem = plen - idx*8;
                for (int j = 0; j < 8; j++) begin
                    s_tdata[8*j +: 8] = (j < rem) ? pay_b[idx*8 + j] : 8'hEE;
                    s_tkeep[j] = (j < rem);
                end
                s_tlast = (idx == nin - 1);
            end else begin
                s_tvalid = 1'b0;
                s_tlast  = 1'b0;
            end
            @(negedge clk);
            hs = s_tvalid && s_tready;
            if (!busy) done = 1'b1;
            if (start_busy && (cyc == 3 || (m_tvalid && m_tready && m_tlast))) start = 1'b1;
            @(posedge clk); #1;
            start = 1'b0;
            cyc++;
            if (hs) begin idx++; s_tvalid = 1'b0; end
            if (check_lat && cyc == 1) chk("no_valid_at_n1", m_tvalid, 1'b0);
            if (check_lat && cyc == 2) chk("first_valid_at_n2", m_tvalid, 1'b1);
            if (abort_at >= 0 && idx >= abort_at) begin
                rst = 1'b1;
                #1;
                chk("abort_m_tvalid", m_tvalid, 1'b0);
                chk("abort_busy", busy, 1'b0);
                chk("abort_s_tready", s_tready, 1'b0);
                chk("abort_m_tlast", m_tlast, 1'b0);
                exp_d.delete(); exp_k.delete(); exp_l.delete();
                s_tvalid = 1'b0; s_tlast = 1'b0;
                @(posedge clk); #1 rst = 1'b0;
                return;
            end
        end
        checks++;
        if (!done) begin
            errors++;
            $display("FAIL frame_timeout actual=%0d cycles required=busy low", cyc);
        end
        chk("input_beats_used", idx, nin);
        chk("frame_beats_left", exp_d.size(), 0);
    endtask

    // Compare every output handshake against the model; check hold-stability while stalled.
    initial begin
        logic [63:0] hd;
        logic [7:0]  hk;
        logic        hl, stall;
        stall = 1'b0; hd = '0; hk = '0; hl = 1'b0;
        forever begin
            @(negedge clk);
            if (rst) begin
                stall = 1'b0;
            end else begin
                if (stall && m_tvalid) begin
                    chk("hold_data", m_tdata, hd);
                    chk("hold_keep", m_tkeep, hk);
                    chk("hold_last", m_tlast, hl);
                end
                if (m_tvalid && m_tready) begin
                    if (exp_d.size() == 0) begin
                        checks++; errors++;
                        $display("FAIL unexpected_beat actual=%h required=no beat", m_tdata);
                    end else begin
                        chk("beat_data", m_tdata, exp_d.pop_front());
                        chk("beat_keep", m_tkeep, exp_k.pop_front());
                        chk("beat_last", m_tlast, exp_l.pop_front());
                    end
                    cap_d.push_back(m_tdata);
                    cap_k.push_back(m_tkeep);
                    cap_l.push_back(m_tlast);
                end
                stall = m_tvalid && !m_tready;
                hd = m_tdata; hk = m_tkeep; hl = m_tlast;
            end
        end
    end

    // Output backpressure driver.
    initial begin
        m_tready = 1'b1;
        forever begin
            @(posedge clk); #1;
            m_tready = thr_en ? ($urandom_range(0, 2) != 0) : 1'b1;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int plen;
        int edge_len [10] = '{1, 2, 3, 6, 7, 8, 9, 10, 16, 1446};
        rst = 1'b1; start = 1'b0;
        s_tdata = '0; s_tkeep = '0; s_tvalid = 1'b0; s_tlast = 1'b0;
        randomize_fields();
        payload_len = 16'd0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_m_tvalid", m_tvalid, 1'b0);
        chk("rst_m_tlast", m_tlast, 1'b0);
        chk("rst_m_tkeep", m_tkeep, 8'h00);
        chk("rst_m_tdata", m_tdata, 64'd0);
        chk("rst_s_tready", s_tready, 1'b0);
        chk("rst_busy", busy, 1'b0);
        rst = 1'b0;
        @(posedge clk); #1;

        // Zero-payload frame with the reference header values.
        run_frame(0, 1'b1, 1'b1, 1'b0, -1);
        chk("model_csum", model_csum, 16'hA548);
        chk("zp_beats", cap_d.size(), 7);
        if (cap_d.size() == 7) begin
            chk("zp_beat0", cap_d[0], 64'h025A0605040302DA);
            chk("zp_beat1", cap_d[1], 64'h0045000806050403);
            chk("zp_totlen", cap_d[2][15:0], 16'h2800);
            chk("zp_csum", cap_d[3][15:0], 16'h48A5);
            chk("zp_last_keep", cap_k[6], 8'h3F);
            chk("zp_last_tlast", cap_l[6], 1'b1);
        end

        // Eight payload bytes: realigned across beat 6 and a flush beat.
        run_frame(8, 1'b1, 1'b0, 1'b0, -1);
        chk("p8_beats", cap_d.size(), 8);
        if (cap_d.size() == 8) begin
            chk("p8_beat6_hi", cap_d[6][63:48], 16'h0201);
            chk("p8_beat7", cap_d[7], 64'h0000080706050403);
            chk("p8_beat7_keep", cap_k[7], 8'h3F);
            chk("p8_beat7_last", cap_l[7], 1'b1);
        end

        // Two payload bytes close the frame in beat 6.
        run_frame(2, 1'b1, 1'b0, 1'b0, -1);
        chk("p2_beats", cap_d.size(), 7);
        if (cap_d.size() == 7) begin
            chk("p2_beat6_keep", cap_k[6], 8'hFF);
            chk("p2_beat6_last", cap_l[6], 1'b1);
        end

        // Throttled 100-byte payload.
        thr_en = 1'b1;
        run_frame(100, 1'b0, 1'b0, 1'b0, -1);

        // Back to back, with stray starts while busy.
        run_frame(37, 1'b0, 1'b0, 1'b1, -1);
        run_frame(13, 1'b0, 1'b0, 1'b0, -1);
        repeat (3) @(posedge clk);
        #1;
        chk("idle_after_ignored_start", busy, 1'b0);

        // Reset during payload, then a clean frame.
        thr_en = 1'b0;
        run_frame(100, 1'b0, 1'b0, 1'b0, 3);
        run_frame(50, 1'b0, 1'b0, 1'b0, -1);

        // Randomized frames.
        for (int i = 0; i < 24; i++) begin
            thr_en = ($urandom_range(0, 1) == 1);
            plen = (i % 3 == 0) ? edge_len[i / 3 % 10] : $urandom_range(0, 200);
            run_frame(plen, 1'b0, 1'b0, (i % 4 == 1), -1);
        end

        thr_en = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        chk("end_busy", busy, 1'b0);
        chk("end_queue", exp_d.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/tx_frame_builder.md
# tx_frame_builder

Transmit-side frame builder for the dataplane. On a start pulse it latches CSR-supplied Ethernet/IPv4/TCP header fields, computes the IPv4 header checksum and emits a 54-byte header on a 64-bit AXI-Stream master. It then appends a payload stream, realigned by 6 byte lanes. It sits between the CSR block and the MAC TX path and is the transmit counterpart of the RX header parser.

## Interface
- No parameters; data width is fixed at 64 bits (8 byte lanes).
- clk  in  1  single clock
- rst  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse; accepted only in IDLE
- busy  out  1  high from accepted start until the final output beat handshakes
- dst_mac, src_mac  in  48 each  MAC addresses; byte 0 on the wire is bits [47:40]
- src_ip, dst_ip  in  32 each  IPv4 addresses; bits [31:24] go first on the wire
- ip_id  in  16  IPv4 identification field
- src_port, dst_port  in  16 each  TCP ports
- tcp_seq, tcp_ack  in  32 each  TCP sequence and acknowledgement numbers
- tcp_flags  in  8  TCP flags byte
- tcp_window  in  16  TCP window size
- payload_len  in  16  payload byte count, 0..1446
- s_tdata  in  64;  s_tkeep  in  8;  s_tvalid  in  1;  s_tlast  in  1;  s_tready  out  1  payload slave
- m_tdata  out  64;  m_tkeep  out  8;  m_tvalid  out  1;  m_tlast  out  1;  m_tready  in  1  frame master

## Operation
- Lane mapping: frame byte n is placed in tdata[8*(n%8)+7 : 8*(n%8)] of beat n/8. Multi-byte fields are big-endian on the wire.
- Header contents, in wire order:
  - dst_mac, src_mac, ethertype 08 00
  - 45 00, total length = 40 + payload_len, ip_id, 40 00 (DF), TTL 40, protocol 06, header checksum, src_ip, dst_ip
  - src_port, dst_port, tcp_seq, tcp_ack, 50, tcp_flags, tcp_window, TCP checksum 00 00, urgent pointer 00 00
- The TCP checksum is always zero. No padding to the 60-byte minimum is added; the MAC pads.
- All header inputs and payload_len are sampled on the accepted start. Later changes to them have no effect on the frame in progress.
- IPv4 checksum: one's-complement sum of the 10 header 16-bit words with the checksum word taken as 0. Fold the carries back into the low 16 bits, then invert the result.
- FSM states:
  - IDLE: start -> CALC.
  - CALC: one cycle; registers the checksum -> HDR.
  - HDR: beats 0..5 -> W6 after beat 5 handshakes.
  - W6: emits header bytes 48..53 plus payload bytes 0..1.
    - payload_len == 0: this is the last beat, keep 0x3F, tlast = 1 -> IDLE.
    - payload_len ≤ 2: this is the last beat, keep has 6 + payload_len ones.
    - Otherwise -> PAY.
  - PAY: each output beat = residual payload bytes 2..7 of the previous input beat in lanes 0..5, plus bytes 0..1 of the current input beat in lanes 6..7.
    - Input s_tlast beat with at most 2 valid bytes: it closes the frame -> IDLE.
    - Input s_tlast beat with more than 2 valid bytes -> FLUSH.
  - FLUSH: emits the residual bytes with keep = (1 << (valid - 2)) - 1 and tlast = 1 -> IDLE.
- Payload rules: s_tkeep must be contiguous from lane 0 and 0xFF on every beat except the s_tlast beat. The byte count given by s_tlast and s_tkeep governs the output. A mismatch with payload_len is not checked.
- s_tready = 1 only in W6 and PAY, and only when the output register is empty or m_tready = 1. When payload_len == 0, s_tready stays 0 and no payload beat is consumed.

## Timing
- Reset values: m_tvalid = 0, m_tlast = 0, m_tkeep = 0, m_tdata = 0, s_tready = 0, busy = 0, FSM in IDLE.
- If start is accepted at edge N, busy = 1 after edge N and the first m_tvalid = 1 appears after edge N+2.
- Full throughput: one output beat per cycle when m_tready and s_tvalid are held high.
- While m_tvalid = 1 and m_tready = 0, m_tdata, m_tkeep and m_tlast hold stable.
- busy drops on the same edge that handshakes the tlast beat. A start arriving in that same cycle is ignored.
- Asserting rst mid-frame aborts immediately, returns every output to its reset value and emits no tlast.

## Test plan
- Zero payload, with dst DA:02:03:04:05:06, src 5A:02:03:04:05:06, src_ip C0A80101, dst_ip C0A80102, ip_id 1234, ports 04D2/0050, seq 1, ack 0, flags 02, window 7210:
  - Beat 0 = 025A0605040302DA, beat 1 = 0045000806050403.
  - Total length 0028, checksum A548.
  - 7 beats; the last beat has keep 0x3F and tlast = 1.
- payload_len 8, one input beat 0x0807060504030201 keep 0xFF:
  - Beat 6 lanes 6..7 = 01 02.
  - Beat 7 = 0x0000080706050403 with keep 0x3F and tlast = 1.
- payload_len 2, keep 0x03 -> beat 6 has keep 0xFF and tlast = 1; no FLUSH beat is emitted.
- Random m_tready throttling with a 100-byte payload -> the byte stream matches the reference model and m_tdata holds stable while stalled.
- Two frames back to back, and start asserted while busy -> the second start is ignored and the first frame is unchanged.
- rst asserted during PAY -> m_tvalid = 0 and busy = 0 immediately, and the next start produces a clean frame.
